// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing the async FIFO write port among NREQ wclk-domain requesters
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int IDW       = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                  wclk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wen,
    output logic [IDW+WIDTH-1:0]  fifo_wdata,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    localparam int CNTW = $clog2(MAX_BURST) + 1;
    localparam logic [CNTW-1:0] BURST_END = CNTW'(MAX_BURST - 1);
    localparam logic [IDW-1:0]  LAST_RST  = IDW'(NREQ - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             xfer;

    logic             rr_found;
    logic [IDW-1:0]   rr_pick;
    int               rr_dist;
    int               rr_best;

    // Payload, valid and last of the requester currently holding the grant.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == IDW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Circular distance from last_grant+1; the closest valid requester wins.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_dist  = 0;
        rr_best  = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            rr_dist = (i + NREQ - int'(last_q) - 1) % NREQ;
            if (req_valid[i] && (rr_dist < rr_best)) begin
                rr_best  = rr_dist;
                rr_pick  = IDW'(i);
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge wclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        busy      = 1'b0;
        xfer      = 1'b0;
        fifo_wen  = 1'b0;
        req_ready = '0;

        case (state_q)
            ST_IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end

            ST_GRANT: begin
                busy     = 1'b1;
                xfer     = sel_valid && !fifo_full;
                fifo_wen = xfer;
                for (int i = 0; i < NREQ; i++) begin
                    req_ready[i] = xfer && (grant_q == IDW'(i));
                end
                if (xfer) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
                // A stalled-but-valid requester keeps the grant; only these end it.
                if (!sel_valid || (xfer && (sel_last || (cnt_q == BURST_END)))) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant_id   = grant_q;
    assign fifo_wdata = {grant_q, sel_data};

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter with a transaction-level round-robin model
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 8;
    localparam int IDW       = 2;
    localparam int MAX_BURST = 4;
    localparam int DW        = IDW + WIDTH;

    logic                  wclk = 1'b0;
    logic                  reset_n = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_last = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full = 1'b0;
    logic                  fifo_wen;
    logic [DW-1:0]         fifo_wdata;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    fifo_wr_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .MAX_BURST(MAX_BURST)
    ) dut (
        .wclk(wclk), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wen(fifo_wen),
        .fifo_wdata(fifo_wdata), .grant_id(grant_id), .busy(busy)
    );

    always #5 wclk = ~wclk;

    logic [WIDTH:0] rq [NREQ][$];
    logic [DW-1:0]  exp_q [$];
    int             m_last = NREQ - 1;
    int             n_vec = 0;
    int             n_err = 0;
    bit             rand_full = 1'b0;

    logic           wen_h  [64];
    logic           busy_h [64];
    logic [IDW-1:0] gid_h  [64];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply();
        logic [WIDTH:0] w;
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
                w = rq[i][0];
                req_valid[i] = 1'b1;
                req_data[i*WIDTH +: WIDTH] = w[WIDTH-1:0];
                req_last[i] = w[WIDTH];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*WIDTH +: WIDTH] = '0;
                req_last[i] = 1'b0;
            end
        end
    endtask

    // mode 0: no last flags, 1: last on final word, 2: random last flags
    task automatic load(int id, int n, int mode);
        logic [WIDTH:0] w;
        for (int k = 0; k < n; k++) begin
            w[WIDTH-1:0] = WIDTH'($urandom);
            case (mode)
                0:       w[WIDTH] = 1'b0;
                1:       w[WIDTH] = (k == n - 1);
                default: w[WIDTH] = ($urandom_range(0, 3) == 0);
            endcase
            rq[id].push_back(w);
        end
    endtask

    // Predict the whole write sequence: bursts end on last, MAX_BURST words, or an empty source.
    task automatic issue();
        int pos [NREQ];
        int cur;
        int n;
        bit fin;
        logic [WIDTH:0] w;
        for (int i = 0; i < NREQ; i++) pos[i] = 0;
        forever begin
            cur = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (cur < 0 && pos[(m_last + k) % NREQ] < rq[(m_last + k) % NREQ].size())
                    cur = (m_last + k) % NREQ;
            end
            if (cur < 0) break;
            n = 0;
            fin = 1'b0;
            while (!fin) begin
                w = rq[cur][pos[cur]];
                exp_q.push_back({IDW'(cur), w[WIDTH-1:0]});
                pos[cur]++;
                n++;
                fin = w[WIDTH] || (n == MAX_BURST) || (pos[cur] == rq[cur].size());
            end
            m_last = cur;
        end
    endtask

    task automatic flush();
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        exp_q.delete();
        m_last = NREQ - 1;
    endtask

    task automatic run_windows(int n);
        for (int w = 0; w < n; w++) begin
            @(negedge wclk);
            wen_h[w]  = fifo_wen;
            busy_h[w] = busy;
            gid_h[w]  = grant_id;
        end
    endtask

    task automatic drain(string name);
        int cyc;
        bit pending;
        cyc = 0;
        do begin
            @(negedge wclk);
            cyc++;
            pending = (exp_q.size() > 0) || busy;
            for (int i = 0; i < NREQ; i++) pending |= (rq[i].size() > 0);
        end while (pending && cyc < 600);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, busy, 0);
    endtask

    // Requester model: pop a word when it was accepted, then present the next one.
    initial begin
        logic [NREQ-1:0] cap;
        forever begin
            @(negedge wclk);
            cap = req_ready;
            @(posedge wclk);
            #1;
            for (int i = 0; i < NREQ; i++)
                if (cap[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            apply();
            if (rand_full) fifo_full = ($urandom_range(0, 9) < 3);
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [DW-1:0]   e;
        logic [NREQ-1:0] exp_rdy;
        forever begin
            @(negedge wclk);
            if (fifo_wen) begin
                check("no_overrun", fifo_full, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", fifo_wen, 0);
                end else begin
                    e = exp_q.pop_front();
                    exp_rdy = '0;
                    exp_rdy[e[DW-1:WIDTH]] = 1'b1;
                    check("wdata", fifo_wdata, e);
                    check("req_ready", req_ready, exp_rdy);
                end
            end else begin
                check("ready_idle", req_ready, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int guard;

        // Reset with requests active.
        #1 reset_n = 1'b0;
        load(0, 2, 1);
        load(2, 2, 1);
        apply();
        repeat (3) begin
            @(negedge wclk);
            check("rst_busy", busy, 0);
            check("rst_wen", fifo_wen, 0);
            check("rst_ready", req_ready, 0);
        end
        flush();
        apply();
        @(negedge wclk);
        reset_n = 1'b1;
        run_windows(3);
        for (int w = 0; w < 3; w++) check("idle_after_rst", busy_h[w], 0);

        // All requesters continuously valid: 0,1,2,3 with one bubble between grants.
        @(negedge wclk);
        for (int i = 0; i < NREQ; i++) load(i, 4, 0);
        issue();
        run_windows(20);
        cnt = 0;
        for (int w = 0; w < 20; w++) cnt += int'(wen_h[w]);
        check("rr_words_in_20", cnt, 16);
        for (int g = 0; g < NREQ; g++) check("rr_grant_order", gid_h[1 + 5*g], g);
        check("rr_bubble", busy_h[5], 0);
        drain("rr");

        // Requester 2 alone, 3-word packet.
        @(negedge wclk);
        load(2, 3, 1);
        issue();
        run_windows(6);
        check("r2_lat_busy0", busy_h[0], 0);
        check("r2_grant", gid_h[1], 2);
        for (int w = 1; w <= 3; w++) check("r2_wen", wen_h[w], 1);
        check("r2_wen_end", wen_h[4], 0);
        check("r2_busy_end", busy_h[4], 0);
        drain("r2");

        // fifo_full stall for 5 cycles after the 2nd word.
        @(negedge wclk);
        load(0, 4, 0);
        issue();
        cnt = 0;
        guard = 0;
        while (cnt < 2 && guard < 50) begin
            @(negedge wclk);
            guard++;
            if (fifo_wen) cnt++;
        end
        check("stall_reach2", cnt, 2);
        @(posedge wclk);
        #1 fifo_full = 1'b1;
        repeat (5) begin
            @(negedge wclk);
            check("stall_wen", fifo_wen, 0);
            check("stall_ready", req_ready, 0);
            check("stall_busy", busy, 1);
            check("stall_gid", grant_id, 0);
        end
        @(posedge wclk);
        #1 fifo_full = 1'b0;
        run_windows(10);
        for (int w = 0; w < 10; w++) cnt += int'(wen_h[w]);
        check("stall_total", cnt, 4);
        drain("stall");

        // Requester 1 drops valid after 2 words; requester 3 waiting.
        @(negedge wclk);
        load(1, 2, 0);
        load(3, 2, 1);
        issue();
        run_windows(9);
        check("drop_gid1", gid_h[1], 1);
        check("drop_hold_wen", wen_h[3], 0);
        check("drop_hold_busy", busy_h[3], 1);
        check("drop_bubble", busy_h[4], 0);
        check("drop_gid3", gid_h[5], 3);
        check("drop_wen3", wen_h[5], 1);
        drain("drop");

        // Reset pulse mid-burst of requester 3.
        @(negedge wclk);
        load(3, 4, 0);
        issue();
        guard = 0;
        do begin
            @(negedge wclk);
            guard++;
        end while (!fifo_wen && guard < 50);
        check("mid_first_word", fifo_wen, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_wen", fifo_wen, 0);
        check("async_ready", req_ready, 0);
        flush();
        @(negedge wclk);
        check("rst_hold_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge wclk);
        load(0, 1, 1);
        load(3, 1, 1);
        issue();
        run_windows(6);
        check("post_rst_gid0", gid_h[1], 0);
        check("post_rst_wen0", wen_h[1], 1);
        check("post_rst_gid3", gid_h[3], 3);
        drain("post_rst");

        // Randomized traffic with random back-pressure.
        rand_full = 1'b1;
        for (int r = 0; r < 25; r++) begin
            @(negedge wclk);
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 2) != 0) load(i, $urandom_range(1, 7), 2);
            issue();
            drain("rand");
        end
        rand_full = 1'b0;
        fifo_full = 1'b0;
        repeat (2) @(negedge wclk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
